// File: rtl/udp_uart_tx_if.sv
// ---------------------------------------------------------------------------
// udp_uart_tx_if
// Byte-strobe bus carrying UDP payload bytes from the Ethernet receive path
// into the UART transmitter.
//   rec_en   : one payload byte per cycle while high
//   rec_data : payload byte, meaningful only when rec_en is high
// Modports:
//   master : producer side (eth_ctrl receive outputs, or a testbench driver)
//   slave  : consumer side (udp_uart_tx)
// ---------------------------------------------------------------------------
interface udp_uart_tx_if;
  logic       rec_en;
  logic [7:0] rec_data;

  modport master (output rec_en, output rec_data);
  modport slave  (input  rec_en, input  rec_data);
endinterface

// File: rtl/udp_uart_tx.sv
// ---------------------------------------------------------------------------
// udp_uart_tx
// Return path of the UART/UDP bridge. Payload bytes arriving on the GMII
// receive clock are buffered in an internal FIFO and serialised onto the
// UART TX pin as 8N1 frames (8E1 when parity is enabled).
//
// Ports:
//   clk      : single clock (gmii_rx_clk domain), rising edge
//   rst_n    : synchronous active-low reset
//   rx       : udp_uart_tx_if.slave, rec_en/rec_data byte strobes
//   uart_txd : UART serial output, idle high
//   tx_busy  : high while a frame is on the line (START..STOP)
//   tx_done  : one-cycle pulse on the last cycle of each STOP bit
//   fifo_cnt : bytes currently buffered (FIFO_AW+1 bits)
//   overflow : sticky, a byte was dropped because the FIFO was full
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, an even-parity bit is sent between the data bits and STOP.
// ---------------------------------------------------------------------------
module udp_uart_tx #(
  parameter int CLK_FREQ = 125_000_000,
  parameter int UART_BPS = 115200,
  parameter int FIFO_AW  = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  udp_uart_tx_if.slave       rx,
  output logic               uart_txd,
  output logic               tx_busy,
  output logic               tx_done,
  output logic [FIFO_AW:0]   fifo_cnt,
  output logic               overflow
);

  localparam int BIT_CYC = CLK_FREQ / UART_BPS;
  localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [FIFO_AW:0] DEPTH    = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               overflow_q, overflow_d;

  logic [7:0]         mem [2**FIFO_AW];

  logic               pop;
  logic               wr_en;
  logic               fifo_full;
  logic               bit_end;

  assign bit_end   = (baud_q == BIT_LAST);
  assign fifo_full = (cnt_q == DEPTH);

  // A pop frees a slot in the same cycle, so a write into a full FIFO is
  // still accepted when it coincides with a pop.
  always_comb begin
    wr_en      = rx.rec_en && (!fifo_full || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (rx.rec_en && !wr_en) begin
      overflow_d = 1'b1;
    end
  end

  // Frame sequencer. The line level is registered and derived from the next
  // state so uart_txd changes on the same edge as the state register.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    txd_d   = 1'b1;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (cnt_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase

    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = ^shift_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      txd_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: reset clears the pointers and count, which
  // makes any stale contents unreachable.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_ptr_q] <= rx.rec_data;
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = (state_q == STOP) && bit_end;
  assign fifo_cnt = cnt_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_udp_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_udp_uart_tx
// Self-checking bench for udp_uart_tx with CLK_FREQ=1000, UART_BPS=100
// (BIT_CYC=10) and FIFO_AW=2 (depth 4). A transaction-level model keeps the
// buffered bytes in a queue and describes each frame as a pop time plus a
// byte; every cycle the expected line level, busy, done, count and overflow
// are derived from that with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_udp_uart_tx;

  localparam int CLK_FREQ = 1000;
  localparam int UART_BPS = 100;
  localparam int FIFO_AW  = 2;
  localparam int BIT      = CLK_FREQ / UART_BPS;
  localparam int DEPTH    = 2 ** FIFO_AW;
`ifdef UART_TX_PARITY_EN
  localparam int NSEG     = 11;
`else
  localparam int NSEG     = 10;
`endif
  localparam int FRAME    = NSEG * BIT + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             uart_txd;
  logic             tx_busy;
  logic             tx_done;
  logic [FIFO_AW:0] fifo_cnt;
  logic             overflow;

  udp_uart_tx_if rec_bus ();

  udp_uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rec_bus.slave),
    .uart_txd (uart_txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .fifo_cnt (fifo_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int         compared   = 0;
  int         mismatched = 0;
  int         cyc        = 0;
  logic [7:0] mq [$];
  logic       m_active   = 1'b0;
  int         m_pop_cyc  = 0;
  logic [7:0] m_byte     = 8'h00;
  int         m_next_idle = 0;
  logic       m_ovf      = 1'b0;
  int         peak;

  task automatic compare(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model update for one rising edge.
  task automatic modelEdge(input logic rst, input logic en, input logic [7:0] d);
    if (rst) begin
      mq.delete();
      m_active    = 1'b0;
      m_ovf       = 1'b0;
      m_next_idle = cyc + 1;
    end else begin
      if (cyc >= m_next_idle && mq.size() > 0) begin
        m_byte      = mq.pop_front();
        m_pop_cyc   = cyc;
        m_active    = 1'b1;
        m_next_idle = cyc + FRAME;
      end
      if (en) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    int   k;
    int   seg;
    logic in_frame;
    logic exp_txd;
    k        = cyc - m_pop_cyc;
    in_frame = m_active && (k >= 0) && (k < NSEG * BIT);
    exp_txd  = 1'b1;
    if (in_frame) begin
      seg = k / BIT;
      if (seg == 0)                   exp_txd = 1'b0;
      else if (seg <= 8)              exp_txd = m_byte[seg-1];
      else if (NSEG == 11 && seg == 9) exp_txd = ^m_byte;
      else                            exp_txd = 1'b1;
    end
    compare({tag, ".txd"},  32'(uart_txd), 32'(exp_txd));
    compare({tag, ".busy"}, 32'(tx_busy),  32'(in_frame));
    compare({tag, ".done"}, 32'(tx_done),  32'(in_frame && (k == NSEG * BIT - 1)));
    compare({tag, ".cnt"},  32'(fifo_cnt), 32'(mq.size()));
    compare({tag, ".ovf"},  32'(overflow), 32'(m_ovf));
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] d, input string tag);
    logic rst;
    rec_bus.rec_en   = en;
    rec_bus.rec_data = d;
    rst = !rst_n;
    @(posedge clk);
    cyc++;
    modelEdge(rst, en, d);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom), tag);
  endtask

  task automatic doReset(input string tag);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'($urandom), tag);
    rst_n = 1'b1;
  endtask

  initial begin
    int   rate;
    logic found;
    rec_bus.rec_en   = 1'b0;
    rec_bus.rec_data = 8'h00;

    // Reset state
    doReset("reset");
    doReset("reset");
    compare("reset.txd_hi", 32'(uart_txd), 32'd1);
    compare("reset.cnt0",   32'(fifo_cnt), 32'd0);

    // Single byte 0x55
    applyStimulus(1'b1, 8'h55, "single");
    idle(FRAME + 20, "single");

    // Burst of three back-to-back bytes, then parity-sensitive bytes
    peak = 0;
    applyStimulus(1'b1, 8'h01, "burst");
    if (fifo_cnt > peak) peak = fifo_cnt;
    applyStimulus(1'b1, 8'h80, "burst");
    if (fifo_cnt > peak) peak = fifo_cnt;
    applyStimulus(1'b1, 8'hFF, "burst");
    if (fifo_cnt > peak) peak = fifo_cnt;
    for (int i = 0; i < 3 * FRAME + 10; i++) begin
      applyStimulus(1'b0, 8'($urandom), "burst");
      if (fifo_cnt > peak) peak = fifo_cnt;
    end
    compare("burst.peak", 32'(peak), 32'd2);
    compare("burst.end_cnt", 32'(fifo_cnt), 32'd0);
    applyStimulus(1'b1, 8'h07, "par07");
    applyStimulus(1'b1, 8'h03, "par03");
    idle(2 * FRAME + 10, "par");

    // Overflow: six bytes into a depth-4 FIFO
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), "ovf");
    compare("ovf.flag", 32'(overflow), 32'd1);
    idle(5 * FRAME + 20, "ovf");
    compare("ovf.sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous write and pop
    doReset("full");
    applyStimulus(1'b1, 8'h11, "full");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hC0 + 8'(i), "full");
    compare("full.cnt4", 32'(fifo_cnt), 32'd4);
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (cyc + 1 >= m_next_idle) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b0, 8'($urandom), "full");
    end
    compare("full.reached_pop", 32'(found), 32'd1);
    applyStimulus(1'b1, 8'h3C, "full_wp");
    compare("full_wp.cnt", 32'(fifo_cnt), 32'd4);
    compare("full_wp.ovf", 32'(overflow), 32'd0);
    idle(5 * FRAME + 20, "full");

    // Reset during DATA bit 3 with two bytes queued
    applyStimulus(1'b1, 8'h5A, "midrst");
    applyStimulus(1'b1, 8'h66, "midrst");
    applyStimulus(1'b1, 8'h99, "midrst");
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_active && (cyc - m_pop_cyc == 4 * BIT + 4)) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b0, 8'($urandom), "midrst");
    end
    compare("midrst.reached_bit3", 32'(found), 32'd1);
    compare("midrst.line_low_before", 32'(tx_busy), 32'd1);
    doReset("midrst");
    compare("midrst.txd", 32'(uart_txd), 32'd1);
    compare("midrst.busy", 32'(tx_busy), 32'd0);
    compare("midrst.cnt", 32'(fifo_cnt), 32'd0);
    idle(2 * FRAME, "midrst_quiet");

    // Randomised traffic with varying byte rate and rare resets
    for (int blk = 0; blk < 16; blk++) begin
      rate = (blk % 3 == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 40));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 1499) == 0) doReset("rand_rst");
        else applyStimulus($urandom_range(0, 99) < rate, 8'($urandom), "rand");
      end
    end
    idle(5 * FRAME + 20, "drain");
    compare("drain.cnt", 32'(fifo_cnt), 32'd0);
    compare("drain.busy", 32'(tx_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/udp_uart_tx.md
Name: udp_uart_tx

Overview:
Return path of the UART/UDP bridge. It takes payload bytes received over UDP on the GMII receive clock and buffers them in an internal FIFO. It then serialises them onto a UART TX line as 8N1 frames. It sits beside the Ethernet top-level, fed by the eth_ctrl UDP receive outputs (rec_en/rec_data strobes), and drives the board UART pin.

Parameters:
CLK_FREQ, 125_000_000, clk frequency in Hz
UART_BPS, 115200, UART bit rate
FIFO_AW, 11, FIFO address width; depth = 2**FIFO_AW bytes (default 2048)

Ports:
clk  input  1  single clock (gmii_rx_clk domain); all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
rec_en  input  1  payload byte strobe, one byte per cycle when high
rec_data  input  8  payload byte, valid when rec_en=1
uart_txd  output  1  UART serial output, idle high
tx_busy  output  1  high while a frame is on the line (START..STOP)
tx_done  output  1  one-cycle pulse on the last cycle of each STOP bit
fifo_cnt  output  FIFO_AW+1  bytes currently buffered
overflow  output  1  sticky flag: a byte was dropped because the FIFO was full

Behaviour:
- Reset (rst_n=0 sampled on a clk edge): uart_txd=1, tx_busy=0, tx_done=0, fifo_cnt=0, overflow=0, state=IDLE, FIFO pointers=0.
- Reset mid-frame aborts the frame: uart_txd is high from the next cycle and all buffered bytes are discarded.
- BIT_CYC = CLK_FREQ/UART_BPS, integer truncation (1085 at defaults).
- Baud counter runs 0..BIT_CYC-1 within each bit and clears on every bit boundary and in IDLE.
- FIFO write: rec_en=1 and fifo_cnt < 2**FIFO_AW -> byte stored at wr_ptr, wr_ptr wraps modulo depth.
- FIFO full: rec_en=1 and fifo_cnt == 2**FIFO_AW -> byte dropped, overflow<=1. overflow clears only on reset.
- FIFO read (pop): only in IDLE when fifo_cnt != 0. The byte at rd_ptr loads into the shift register, rd_ptr wraps modulo depth.
- Simultaneous write and pop: fifo_cnt unchanged; both pointers advance.
- Pop when full with a simultaneous write: both succeed, because the pop frees the slot in the same cycle. overflow is not set.
- fifo_cnt is registered and reflects the current cycle's write/pop from the next cycle.
- State machine:
  - IDLE: uart_txd=1, tx_busy=0. If fifo_cnt != 0: pop and go to START.
  - START: uart_txd=0 for BIT_CYC cycles, then go to DATA with bit_idx=0.
  - DATA: uart_txd = shift[bit_idx], LSB first, BIT_CYC cycles per bit. After bit_idx=7 go to STOP.
  - STOP: uart_txd=1 for BIT_CYC cycles. tx_done=1 on the final cycle, then go to IDLE.
- tx_busy=1 in START, DATA and STOP.
- Latency: a byte written into an empty FIFO while in IDLE makes uart_txd fall 2 cycles after the rec_en cycle (cycle 1 = write, cycle 2 = pop/enter START, uart_txd low from the cycle after the pop).
- Back-to-back frames: exactly one IDLE cycle (uart_txd=1) between the end of STOP and the next START. Frame period = 10*BIT_CYC+1 cycles.
- rec_data is ignored when rec_en=0. No byte is ever transmitted twice or reordered.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It lasts BIT_CYC cycles and drives uart_txd = XOR of the 8 data bits (even parity). Frame = 11 bits; period = 11*BIT_CYC+1.
- Not defined: no PARITY state; 8N1 framing exactly as above.

Test Plan:
- Single byte. Params CLK_FREQ=1000, UART_BPS=100 (BIT_CYC=10). Write 0x55 once -> uart_txd low from cycle 2 for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high 10 cycles. tx_done pulses once at cycle 101; tx_busy high for cycles 2..101.
- Burst. Write 0x01,0x80,0xFF on 3 consecutive cycles -> three frames in order, each 101 cycles apart, with one idle-high cycle between them. fifo_cnt peaks at 2 and ends at 0.
- Overflow. FIFO_AW=2 (depth 4), BIT_CYC=10. Write 6 bytes 0xA0..0xA5 on consecutive cycles -> 0xA0 is popped on the cycle after its write, 4 further bytes are stored, 1 byte (0xA5) is dropped. overflow=1; the line outputs 0xA0..0xA4 only.
- Full with simultaneous write/pop. Fill to 4 while a frame is active, then on the IDLE pop cycle also write 0x3C -> fifo_cnt stays 4, overflow stays 0, and 0x3C is transmitted last.
- Reset mid-frame. Assert rst_n=0 for 1 cycle during DATA bit 3 with 2 bytes queued -> uart_txd=1, tx_busy=0 and fifo_cnt=0 next cycle; no further frames follow.
- Parity (UART_TX_PARITY_EN defined). Write 0x07 -> parity bit 1 after the data bits; write 0x03 -> parity bit 0. Frame period is 111 cycles.
